// File: rtl/recip_sched_pkg.sv
// Shared definitions for the reciprocal scheduler: flag bit positions,
// FSM encoding and floating-point format constants.
package recip_sched_pkg;

  localparam int NFLAGS      = 5;
  localparam int F_INEXACT   = 0;
  localparam int F_UNDERFLOW = 1;
  localparam int F_OVERFLOW  = 2;
  localparam int F_DIV_ZERO  = 3;
  localparam int F_INVALID   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int HP_EXP_W = 5;
  localparam int HP_MAN_W = 10;

  function automatic int exp_w(input int fmt);
    return (fmt == 16) ? HP_EXP_W : SP_EXP_W;
  endfunction

  function automatic int man_w(input int fmt);
    return (fmt == 16) ? HP_MAN_W : SP_MAN_W;
  endfunction

endpackage

// File: rtl/recip_fp.sv
// Combinational IEEE reciprocal, round-to-nearest-even. Subnormal inputs are
// treated as zero and tiny results flush to signed zero, so the smallest
// normal input maps to a representable result and overflow cannot occur.
module recip_fp
  import recip_sched_pkg::*;
#(
  parameter int TYPE = 32
) (
  input  logic [TYPE-1:0]   in_bits,
  output logic [TYPE-1:0]   out_bits,
  output logic [NFLAGS-1:0] except_flags
);

  localparam int EW = exp_w(TYPE);
  localparam int MW = man_w(TYPE);
  localparam logic [EW+1:0] TWO_BIAS = (EW+2)'((1 << EW) - 2);

  logic          sign;
  logic [EW-1:0] exp_in;
  logic [MW-1:0] man_in;
  assign {sign, exp_in, man_in} = in_bits;

  logic [MW+1:0] den, rmd, quo;
  logic          round_up, inexact;
  logic [MW:0]   man_rnd;
  logic [EW+1:0] exp_res;

  // Restoring division of 2.0 by 1.m; the integer bit is always 1 and implied.
  always_comb begin
    den = {2'b01, man_in};
    rmd = {2'b10, {MW{1'b0}}} - den;
    quo = '0;
    for (int i = MW + 1; i >= 0; i--) begin
      rmd = rmd << 1;
      if (rmd >= den) begin
        quo[i] = 1'b1;
        rmd    = rmd - den;
      end
    end
    round_up = quo[1] & (quo[0] | (|rmd) | quo[2]);
    man_rnd  = {1'b0, quo[MW+1:2]} + (MW+1)'(round_up);
    inexact  = quo[1] | quo[0] | (|rmd);
    if (man_in == '0) begin
      // Power of two: exact, and 2/1.0 lands one exponent step higher.
      man_rnd = '0;
      inexact = 1'b0;
      exp_res = TWO_BIAS - {2'b00, exp_in};
    end else begin
      exp_res = TWO_BIAS - {2'b00, exp_in} - (EW+2)'(1) + (EW+2)'(man_rnd[MW]);
    end
  end

  // Special-case selection and result packing.
  always_comb begin
    out_bits     = '0;
    except_flags = '0;
    if (exp_in == '1) begin
      if (man_in != '0) begin
        out_bits                = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        except_flags[F_INVALID] = 1'b1;
      end else begin
        out_bits = {sign, {(TYPE-1){1'b0}}};
      end
    end else if (exp_in == '0) begin
      out_bits                 = {sign, {EW{1'b1}}, {MW{1'b0}}};
      except_flags[F_DIV_ZERO] = 1'b1;
    end else if (exp_res[EW+1] || exp_res == '0) begin
      out_bits                  = {sign, {(TYPE-1){1'b0}}};
      except_flags[F_UNDERFLOW] = 1'b1;
      except_flags[F_INEXACT]   = 1'b1;
    end else begin
      out_bits                 = {sign, exp_res[EW-1:0], man_rnd[MW-1:0]};
      except_flags[F_INEXACT]  = inexact;
      except_flags[F_OVERFLOW] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first active request strictly after 'last', with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  // Scan from farthest to nearest so the nearest active request wins.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        grant       = IW'((int'(last) + k) % N);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recip_sched.sv
// Round-robin scheduler sharing one multicycle reciprocal unit between
// N_REQ requesters, one operation in flight, with sticky exception flags.
module recip_sched
  import recip_sched_pkg::*;
#(
  parameter int TYPE        = 32,
  parameter int N_REQ       = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*TYPE-1:0]   req_bits,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [TYPE-1:0]         resp_bits,
  output logic [NFLAGS-1:0]       resp_flags,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                    busy,
  output logic [NFLAGS-1:0]       sticky_flags,
  input  logic                    flags_clr
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [IDW-1:0]    last_grant, id_reg, grant;
  logic              grant_valid;
  logic [CW-1:0]     exec_cnt;
  logic [TYPE-1:0]   op_reg, fp_bits;
  logic [NFLAGS-1:0] fp_flags;
  logic              take, cap, hs;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .req         (req_valid),
    .last        (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  recip_fp #(.TYPE(TYPE)) u_fp (
    .in_bits      (op_reg),
    .out_bits     (fp_bits),
    .except_flags (fp_flags)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, grant strobe and the per-state control pulses.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    take      = 1'b0;
    cap       = 1'b0;
    hs        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no requester sees an accept while reset is held.
        if (grant_valid && rst_n) begin
          req_ready[grant] = 1'b1;
          take             = 1'b1;
          state_d          = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_cnt == '0) begin
          cap     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          hs      = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, cycle budget countdown and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(N_REQ - 1);
      exec_cnt   <= '0;
      op_reg     <= '0;
      id_reg     <= '0;
      resp_bits  <= '0;
      resp_flags <= '0;
    end else begin
      if (take) begin
        op_reg     <= req_bits[int'(grant)*TYPE +: TYPE];
        id_reg     <= grant;
        last_grant <= grant;
        exec_cnt   <= CW'(EXEC_CYCLES - 1);
      end else if (state_q == S_EXEC && exec_cnt != '0) begin
        exec_cnt <= exec_cnt - CW'(1);
      end
      if (cap) begin
        resp_bits  <= fp_bits;
        resp_flags <= fp_flags;
      end
    end
  end

  // Sticky flags: a clear coinciding with a handshake keeps the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sticky_flags <= '0;
    else if (hs && flags_clr)  sticky_flags <= resp_flags;
    else if (hs)               sticky_flags <= sticky_flags | resp_flags;
    else if (flags_clr)        sticky_flags <= '0;
  end

  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_id    = id_reg;

endmodule

// File: tb/tb_recip_sched.sv
// Directed bench for recip_sched with hand-computed single-precision results.
module tb_recip_sched;

  localparam int TYPE = 32;
  localparam int N    = 4;
  localparam int EC   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*TYPE-1:0] req_bits = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [TYPE-1:0] resp_bits;
  logic [4:0]      resp_flags;
  logic [1:0]      resp_id;
  logic            busy;
  logic [4:0]      sticky_flags;
  logic            flags_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  recip_sched #(.TYPE(TYPE), .N_REQ(N), .EXEC_CYCLES(EC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_bits     (req_bits),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_bits    (resp_bits),
    .resp_flags   (resp_flags),
    .resp_id      (resp_id),
    .busy         (busy),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    flags_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    req_bits[i*TYPE +: TYPE] = v;
  endtask

  // Wait for the grant to g, drop that request, then check latency, result and handshake.
  task automatic run_op(input string tag, input int g, input logic [31:0] exp_bits,
                        input logic [4:0] exp_flags, input int hold, input logic clr);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".grant"}, 32'(req_ready), 32'(1 << g));
    @(posedge clk);
    #1 req_valid[g] = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(EC));
    check({tag, ".bits"},  resp_bits, exp_bits);
    check({tag, ".flags"}, 32'(resp_flags), 32'(exp_flags));
    check({tag, ".id"},    32'(resp_id), 32'(g));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_bits"},  resp_bits, exp_bits);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    flags_clr  = clr;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    flags_clr  = 1'b0;
    check({tag, ".done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state.
    apply_reset();
    check("rst.valid",  32'(resp_valid), 32'd0);
    check("rst.busy",   32'(busy), 32'd0);
    check("rst.ready",  32'(req_ready), 32'd0);
    check("rst.bits",   resp_bits, 32'd0);
    check("rst.flags",  32'(resp_flags), 32'd0);
    check("rst.sticky", 32'(sticky_flags), 32'd0);

    // +0 from requester 0 -> +inf, div_zero.
    set_op(0, 32'h0000_0000);
    req_valid = 4'b0001;
    run_op("zero", 0, 32'h7F80_0000, 5'h08, 0, 1'b0);
    check("zero.sticky", 32'(sticky_flags), 32'h08);
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    check("clr.sticky", 32'(sticky_flags), 32'h00);

    // All four requesters from reset: grants 0,1,2,3.
    apply_reset();
    set_op(0, 32'h7F80_0000);
    set_op(1, 32'h8000_0000);
    set_op(2, 32'h7FC0_0001);
    set_op(3, 32'h0000_0000);
    req_valid = 4'b1111;
    run_op("rr0", 0, 32'h0000_0000, 5'h00, 0, 1'b0);
    run_op("rr1", 1, 32'hFF80_0000, 5'h08, 0, 1'b0);
    run_op("rr2", 2, 32'h7FC0_0000, 5'h10, 0, 1'b0);
    check("rr.sticky", 32'(sticky_flags), 32'h18);
    run_op("rr3", 3, 32'h7F80_0000, 5'h08, 0, 1'b0);

    // 1/3 is inexact; flags_clr at the handshake leaves only the new flag.
    set_op(1, 32'h4040_0000);
    req_valid = 4'b0010;
    run_op("third", 1, 32'h3EAA_AAAB, 5'h01, 0, 1'b1);
    check("third.sticky", 32'(sticky_flags), 32'h01);
    set_op(2, 32'h3F80_0000);
    req_valid = 4'b0100;
    run_op("one", 2, 32'h3F80_0000, 5'h00, 0, 1'b0);

    // Backpressure with a waiting requester 1.
    apply_reset();
    set_op(0, 32'h4080_0000);
    set_op(1, 32'h4000_0000);
    req_valid = 4'b0011;
    run_op("bp0", 0, 32'h3E80_0000, 5'h00, 5, 1'b0);
    check("bp.next_grant", 32'(req_ready), 32'b0010);
    run_op("bp1", 1, 32'h3F00_0000, 5'h00, 0, 1'b0);

    // Reset in the middle of EXEC.
    set_op(2, 32'h4040_0000);
    req_valid = 4'b0100;
    @(negedge clk);
    check("mid.grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    check("mid.busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid.busy",   32'(busy), 32'd0);
    check("mid.valid",  32'(resp_valid), 32'd0);
    check("mid.bits",   resp_bits, 32'd0);
    check("mid.id",     32'(resp_id), 32'd0);
    req_valid = 4'b0101;
    #1 check("mid.ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 if (resp_valid) seen++;
    end
    check("mid.no_resp", 32'(seen), 32'd0);
    set_op(0, 32'h3F80_0000);
    set_op(2, 32'hFF80_0000);
    req_valid = 4'b0101;
    run_op("post0", 0, 32'h3F80_0000, 5'h00, 0, 1'b0);
    run_op("post2", 2, 32'h8000_0000, 5'h00, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/recip_sched.md
RECIP_SCHED -- requirements
Module: recip_sched

Interface
REQ-001 SHALL have parameter TYPE, default 32, operand format: 32 = single precision, 16 = half precision.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 SHALL have parameter EXEC_CYCLES, default 2, multicycle budget for the shared reciprocal datapath; legal minimum 1.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ bits; per-requester operand valid.
REQ-007 SHALL have port req_ready, output, N_REQ bits; per-requester accept, at most one bit high at a time.
REQ-008 SHALL have port req_bits, input, N_REQ*TYPE bits; flattened operands, requester i at [i*TYPE +: TYPE].
REQ-009 SHALL have port resp_valid, output, 1 bit; result available.
REQ-010 SHALL have port resp_ready, input, 1 bit; consumer accept.
REQ-011 SHALL have port resp_bits, output, TYPE bits; reciprocal result.
REQ-012 SHALL have port resp_flags, output, 5 bits; flags [0]inexact [1]underflow [2]overflow [3]div_zero [4]invalid.
REQ-013 SHALL have port resp_id, output, clog2(N_REQ) bits; index of the requester that owns the result.
REQ-014 SHALL have port busy, output, 1 bit; high whenever state is not IDLE.
REQ-015 SHALL have port sticky_flags, output, 5 bits; accumulated flags.
REQ-016 SHALL have port flags_clr, input, 1 bit; clears sticky_flags.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and RESP; one operation in flight at a time.
REQ-018 In IDLE with any req_valid high, the block SHALL grant round-robin, searching from last_grant+1 upward with wrap, and assert req_ready[g] combinationally in that cycle only.
REQ-019 On grant, the block SHALL register req_bits[g] into op_reg and g into id_reg, update last_grant to g, load exec_cnt = EXEC_CYCLES-1, and enter EXEC.
REQ-020 req_ready SHALL be all-zero in EXEC and RESP; requests arriving there wait.
REQ-021 op_reg SHALL drive the shared recip_fp datapath directly; its outputs are sampled only when exec_cnt==0.
REQ-022 In EXEC, exec_cnt SHALL decrement each cycle; at exec_cnt==0 the block SHALL capture out_bits into resp_bits and except_flags into resp_flags, then enter RESP.
REQ-023 Grant-to-resp_valid latency SHALL be exactly EXEC_CYCLES cycles.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_bits, resp_flags and resp_id SHALL hold stable until resp_ready.
REQ-025 On handshake (resp_valid && resp_ready), the block SHALL return to IDLE; the next grant is no earlier than the following cycle.
REQ-026 On handshake, sticky_flags SHALL become sticky_flags | resp_flags.
REQ-027 flags_clr alone SHALL zero sticky_flags; flags_clr in the same cycle as a handshake SHALL load sticky_flags = resp_flags, so the new flags win.
REQ-028 A requester dropping req_valid outside its grant cycle SHALL have no effect; a dropped request is never latched.
REQ-029 resp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-030 While rst_n is low, asynchronously: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), exec_cnt=0, op_reg=0, id_reg=0, resp_bits=0, resp_flags=0, sticky_flags=0.
REQ-031 Reset mid-EXEC or mid-RESP SHALL abandon the operation; no response is emitted after release.

Structure
REQ-032 A shared package SHALL hold the flag bit indices (F_INEXACT..F_INVALID), the FSM state encoding, and the format constants for TYPE 16 and 32.
REQ-033 The block SHALL instantiate recip_fp once as the shared resource.
REQ-034 Round-robin selection SHALL be a separate sub-module rr_arbiter (inputs req, last; outputs grant index, grant_valid).

Verification
REQ-035 Requester 0 sends 0x00000000 -> resp_bits 0x7F800000, flags 0x08, id 0, resp_valid exactly 2 cycles after grant.
REQ-036 All four requesters valid from reset with operands 0x7F800000, 0x80000000, 0x7FC00001 and 0x00000000 -> grants in order 0,1,2,3 with results 0x00000000/0x00, 0xFF800000/0x08, 0x7FC00000/0x10, 0x7F800000/0x08.
REQ-037 resp_ready held low 5 cycles in RESP with requester 1 valid -> outputs stable, req_ready all-zero, then grant to 1 the cycle after the handshake.
REQ-038 Flags sequence 0x08 then 0x10 -> sticky_flags 0x18; flags_clr coincident with a 0x01 handshake -> sticky_flags 0x01.
REQ-039 rst_n low during EXEC -> all outputs zero immediately, no resp_valid after release, next grant to requester 0.
